fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised instruction buffer between the fetch source and DecodeStage. It replaces
//   the direct instr/valid/stall hookup with a DEPTH-entry FIFO, so fetch and decode stalls
//   are decoupled. Pipeline flush from WriteBackStage discards all buffered entries.
//   Optional fall-through mode gives zero-latency passing when the queue is empty.
// PARAMETERS
//   WIDTH        64  bits per entry (packed Uop::fetch_t: pc + instr)
//   DEPTH        4   number of entries; power of two, >= 2
//   FALLTHROUGH  0   1: empty queue passes in_data to out_data combinationally
// PORTS
//   clk        in   1              clock, all state on rising edge
//   rst        in   1              asynchronous reset, active-low (0 = reset)
//   flush      in   1              synchronous discard of all entries
//   in_valid   in   1              upstream entry present
//   in_data    in   WIDTH          upstream entry
//   in_stall   out  1              queue cannot accept; upstream must hold in_data
//   out_valid  out  1              entry presented to decode
//   out_data   out  WIDTH          head entry (or bypassed in_data)
//   out_stall  in   1              decode not accepting; head must be held
//   count      out  $clog2(DEPTH+1) number of stored entries
// BEHAVIOUR
//   - Reset (rst=0, async): rd/wr pointers=0, count=0, in_stall=0, out_valid=0.
//     out_data is don't-care; storage array is not reset. Reset mid-stream drops all
//     entries immediately, with no partial state.
//   - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
//     Full/empty come from count: full = (count==DEPTH), empty = (count==0).
//   - in_stall = full. It is a function of registered state only, with no path from out_stall.
//   - enq = in_valid & ~in_stall & ~flush. deq = out_valid & ~out_stall.
//   - FALLTHROUGH=0: out_valid = ~empty & ~flush; out_data = mem[rd_ptr].
//     Latency is 1 cycle from an accepted input to out_valid.
//   - FALLTHROUGH=1, when empty & in_valid & ~flush:
//     - out_valid=1 and out_data=in_data in the same cycle.
//     - If ~out_stall, the entry is consumed directly: no write, count unchanged.
//     - Otherwise it is written as a normal enq.
//   - Simultaneous enq & deq (not bypassed): write at wr_ptr, read at rd_ptr, count unchanged.
//     This is legal at any non-full count. When full, in_stall=1, so no enq occurs.
//   - flush (priority over everything except rst): next edge sets rd_ptr=wr_ptr=0 and count=0.
//     The input that cycle is dropped even if in_valid=1. out_valid is forced 0 during the
//     flush cycle, so decode never consumes a flushed entry.
//   - Count update: count_next = count + enq_w - deq_r. enq_w = written enq; deq_r = read
//     from storage, excluding bypass. Width never overflows; assert count<=DEPTH.
//   - Held outputs: while out_valid & out_stall, out_data is stable until deq or flush.
//   - No state machine beyond pointers/count. Illegal DEPTH (not pow2 or <2) -> $error
//     at elaboration.
// TESTING
//   1. Reset: rst=0 with in_valid=1 -> count=0, out_valid=0, in_stall=0. Release rst,
//      push 0xA -> out_valid=1 next cycle with out_data=0xA.
//   2. Fill: DEPTH=4, out_stall=1, push 0x1..0x5 -> count=4, in_stall=1 after the 4th push,
//      0x5 held upstream. Release out_stall -> pops 0x1,0x2,0x3,0x4,0x5 in order.
//   3. Wrap: 10 push/pop pairs at count=2 steady -> data order preserved across two pointer
//      wraps, count stays 2.
//   4. Flush: count=3, assert flush with in_valid=1 (0xF) -> out_valid=0 that cycle; next cycle
//      count=0, out_valid=0, 0xF never appears at the output.
//   5. Fall-through: FALLTHROUGH=1, empty, in_data=0x77, out_stall=0 -> out_valid=1 and
//      out_data=0x77 the same cycle, count stays 0. Repeat with out_stall=1 -> count=1 next cycle.
//   6. Full + pop: count=4 with in_valid=1 and out_stall=0 -> in_stall=1, one pop, count=3.
//      The next cycle the entry is accepted and count returns to 4.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO with flush and an
// optional zero-latency fall-through path when the queue is empty.
module fetch_queue #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned DEPTH       = 4,
  parameter bit          FALLTHROUGH = 1'b0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_in_valid,
  input  logic [WIDTH-1:0]             i_in_data,
  output logic                         o_in_stall,
  output logic                         o_out_valid,
  output logic [WIDTH-1:0]             o_out_data,
  input  logic                         i_out_stall,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;

  logic             w_empty;
  logic             w_bypass;
  logic             w_enq;
  logic             w_deq;
  logic             w_wr;
  logic             w_rd;
  logic [CW-1:0]    w_count_nxt;

  assign w_empty  = (r_count == '0);
  // Bypass only when nothing is buffered, so ordering is never violated.
  assign w_bypass = FALLTHROUGH && w_empty && i_in_valid && !i_flush;

  assign o_out_valid = (!w_empty || w_bypass) && !i_flush;
  assign o_out_data  = w_bypass ? i_in_data : r_mem[r_rd_ptr];
  assign o_in_stall  = r_full;
  assign o_count     = r_count;

  assign w_enq = i_in_valid && !r_full && !i_flush;
  assign w_deq = o_out_valid && !i_out_stall;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign w_wr  = w_enq && !(w_bypass && !i_out_stall);
  assign w_rd  = w_deq && !w_bypass;

  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);

  // Pointers, occupancy and the registered full flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_in_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (r_count <= CW'(DEPTH))
        else $error("fetch_queue: occupancy exceeds DEPTH");
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: one buffered and one fall-through instance, directed
// scenarios followed by random traffic, all checked against queue-based models.
module tb_fetch_queue;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic [1:0]       flush;
  logic [1:0]       in_valid;
  logic [1:0]       in_stall;
  logic [1:0]       out_valid;
  logic [1:0]       out_stall;
  logic [WIDTH-1:0] in_data  [2];
  logic [WIDTH-1:0] out_data [2];
  logic [CW-1:0]    count    [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] mq0 [$];
  logic [WIDTH-1:0] mq1 [$];
  logic [1:0]       accepted;

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FALLTHROUGH(1'b0)) u_dut_buf (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush[0]),
    .i_in_valid(in_valid[0]), .i_in_data(in_data[0]), .o_in_stall(in_stall[0]),
    .o_out_valid(out_valid[0]), .o_out_data(out_data[0]),
    .i_out_stall(out_stall[0]), .o_count(count[0])
  );

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FALLTHROUGH(1'b1)) u_dut_ft (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush[1]),
    .i_in_valid(in_valid[1]), .i_in_data(in_data[1]), .o_in_stall(in_stall[1]),
    .o_out_valid(out_valid[1]), .o_out_data(out_data[1]),
    .i_out_stall(out_stall[1]), .o_count(count[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check both instances against their models, then advance one clock.
  task automatic cycle();
    int               sz;
    int               sz_v [2];
    logic [WIDTH-1:0] ed;
    logic             ev;
    logic [1:0]       pop_v;
    if (!rst_n) begin
      mq0.delete();
      mq1.delete();
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      sz = (k == 0) ? mq0.size() : mq1.size();
      ev = 1'b0;
      ed = '0;
      if (!rst_n || flush[k]) ev = 1'b0;
      else if (sz > 0) begin
        ev = 1'b1;
        ed = (k == 0) ? mq0[0] : mq1[0];
      end else if (k == 1 && in_valid[k]) begin
        ev = 1'b1;
        ed = in_data[k];
      end
      check($sformatf("count%0d", k), 64'(count[k]), 64'(sz));
      check($sformatf("in_stall%0d", k), 64'(in_stall[k]), 64'(sz == int'(DEPTH)));
      check($sformatf("out_valid%0d", k), 64'(out_valid[k]), 64'(ev));
      if (ev) check($sformatf("out_data%0d", k), out_data[k], ed);
      accepted[k] = rst_n && !flush[k] && in_valid[k] && (sz < int'(DEPTH));
      pop_v[k]    = ev && !out_stall[k];
      sz_v[k]     = sz;
    end
    @(posedge clk);
    if (rst_n) begin
      if (flush[0]) mq0.delete();
      else begin
        if (pop_v[0]) void'(mq0.pop_front());
        if (accepted[0]) mq0.push_back(in_data[0]);
      end
      if (flush[1]) mq1.delete();
      else if (!(sz_v[1] == 0 && pop_v[1])) begin
        if (pop_v[1]) void'(mq1.pop_front());
        if (accepted[1]) mq1.push_back(in_data[1]);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    flush = '0; in_valid = '0; out_stall = '0;
    in_data[0] = '0; in_data[1] = '0;
  endtask

  initial begin
    logic [63:0] v;
    rst_n = 1'b0;
    idle();
    in_valid[0] = 1'b1;
    in_data[0]  = 64'hA;
    @(negedge clk);
    cycle();
    // Push 0xA after reset release; it must appear one cycle later.
    rst_n = 1'b1;
    cycle();
    in_valid[0] = 1'b0;
    cycle();
    cycle();

    // Fill to full with decode stalled, 0x5 held upstream, then drain in order.
    out_stall[0] = 1'b1;
    v = 64'h1;
    for (int n = 0; n < 7; n++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = v;
      cycle();
      if (accepted[0]) v++;
    end
    out_stall[0] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      in_valid[0] = (v <= 64'h5);
      in_data[0]  = v;
      cycle();
      if (accepted[0]) v++;
    end
    idle();

    // Steady state at two entries across several pointer wraps.
    out_stall[0] = 1'b1;
    in_valid[0]  = 1'b1;
    v = 64'h10;
    for (int n = 0; n < 2; n++) begin
      in_data[0] = v;
      cycle();
      v++;
    end
    out_stall[0] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      in_data[0] = v;
      cycle();
      v++;
    end

    // Reach three entries, then flush with a live input that must be dropped.
    out_stall[0] = 1'b1;
    in_data[0]   = v;
    cycle();
    flush[0]    = 1'b1;
    in_data[0]  = 64'hF;
    cycle();
    idle();
    cycle();
    cycle();

    // Full queue with a pop: refused input is accepted the following cycle.
    out_stall[0] = 1'b1;
    in_valid[0]  = 1'b1;
    for (int n = 0; n < 4; n++) begin
      in_data[0] = 64'h20 + 64'(n);
      cycle();
    end
    in_data[0]   = 64'h99;
    out_stall[0] = 1'b0;
    cycle();
    out_stall[0] = 1'b1;
    cycle();
    idle();
    for (int n = 0; n < 6; n++) cycle();

    // Fall-through: consumed directly, then written when decode stalls.
    in_valid[1] = 1'b1;
    in_data[1]  = 64'h77;
    cycle();
    out_stall[1] = 1'b1;
    in_data[1]   = 64'h78;
    cycle();
    in_valid[1] = 1'b0;
    cycle();
    out_stall[1] = 1'b0;
    cycle();
    cycle();

    // Random traffic on both instances with occasional flush and one mid-stream reset.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = 1'($urandom_range(0, 1));
        in_data[k]   = {$urandom, $urandom};
        out_stall[k] = ($urandom_range(0, 2) == 0);
        flush[k]     = ($urandom_range(0, 15) == 0);
      end
      if (n == 300) begin
        rst_n = 1'b0;
        in_valid[1] = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      cycle();
    end
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
